univ_reg: RTL and testbench

UNIV_REG -- requirements
Module: univ_reg

---
 rtl/univ_reg_pkg.sv | 56 +++++
 rtl/univ_reg_step.sv | 24 ++
 rtl/univ_reg.sv | 106 ++++++++++
 tb/tb_univ_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - mode/state enums and the shared next-value step function for univ_reg
package univ_reg_pkg;

  // Widest register the step function supports.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_SHR   = 3'd3,
    MODE_ROTL  = 3'd4,
    MODE_ROTR  = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_multi(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
           (m == MODE_ROTR) || (m == MODE_ASR);
  endfunction

  // value/load are zero-extended to MAX_W; msb is a one-hot mask of the real MSB.
  // Bits above the real width may be garbage after a left move; callers truncate.
  function automatic logic [MAX_W-1:0] step_value(
    input logic [MAX_W-1:0] value,
    input logic [MAX_W-1:0] load,
    input logic [MAX_W-1:0] msb,
    input mode_e            mode,
    input logic             ser_l,
    input logic             ser_r
  );
    logic [MAX_W-1:0] r;
    logic             top;
    top = |(value & msb);
    r   = value;
    case (mode)
      MODE_HOLD:  r = value;
      MODE_LOAD:  r = load;
      MODE_SHL:   r = {value[MAX_W-2:0], ser_r};
      MODE_SHR:   r = (value >> 1) | (ser_l ? msb : '0);
      MODE_ROTL:  r = {value[MAX_W-2:0], top};
      MODE_ROTR:  r = (value >> 1) | (value[0] ? msb : '0);
      MODE_ASR:   r = (value >> 1) | (top ? msb : '0);
      MODE_CLEAR: r = '0;
      default:    r = value;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_reg_step.sv
// rtl/univ_reg_step.sv - combinational next-value logic shared by single-cycle and multi-step paths
module univ_reg_step
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] load,
  input  logic [2:0]       mode,
  input  logic             ser_l,
  input  logic             ser_r,
  output logic [WIDTH-1:0] next
);

  localparam logic [MAX_W-1:0] MSB = MAX_W'(1) << (WIDTH - 1);

  logic [MAX_W-1:0] full;
  logic             unused_hi;

  assign full      = step_value(MAX_W'(value), MAX_W'(load), MSB, mode_e'(mode), ser_l, ser_r);
  assign next      = full[WIDTH-1:0];
  assign unused_hi = ^(full >> WIDTH);

endmodule

// File: rtl/univ_reg.sv
// rtl/univ_reg.sv - universal shift register with multi-step FSM; UNIV_REG_PARITY_EN adds a parity output
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
`ifdef UNIV_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  state_e           state, state_n;
  mode_e            mode_q, mode_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] value_n;
  logic [WIDTH-1:0] step_out;
  logic [2:0]       step_mode;
  logic             done_n;
  logic             start_ok;

  // The one step unit follows the latched mode while running, the live mode otherwise.
  assign step_mode = (state == ST_RUN) ? mode_q : mode;
  assign start_ok  = start && is_multi(mode_e'(mode));

  univ_reg_step #(.WIDTH(WIDTH)) u_step (
    .value (par_out),
    .load  (par_in),
    .mode  (step_mode),
    .ser_l (ser_in_l),
    .ser_r (ser_in_r),
    .next  (step_out)
  );

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    cnt_n   = cnt;
    value_n = par_out;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          if (amt != '0) begin
            state_n = ST_RUN;
            mode_n  = mode_e'(mode);
            cnt_n   = amt;
          end else begin
            done_n = 1'b1;
          end
        end else if (en) begin
          value_n = step_out;
        end
      end
      ST_RUN: begin
        value_n = step_out;
        cnt_n   = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt     <= '0;
      par_out <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      cnt     <= cnt_n;
      par_out <= value_n;
      done    <= done_n;
    end
  end

  assign busy      = (state == ST_RUN);
  assign ser_out_l = par_out[WIDTH-1];
  assign ser_out_r = par_out[0];

`ifdef UNIV_REG_PARITY_EN
  assign parity = ^par_out;
`endif

endmodule

// File: tb/tb_univ_reg.sv
// tb/tb_univ_reg.sv - directed self-checking bench for univ_reg
module tb_univ_reg;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             ser_in_l;
  logic             ser_in_r;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] par_out;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;
`ifdef UNIV_REG_PARITY_EN
  logic             parity;
`endif

  int tests = 0;
  int fails = 0;

  univ_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .par_in    (par_in),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .amt       (amt),
    .par_out   (par_out),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
`ifdef UNIV_REG_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [3:0] v, input logic b, input logic d);
    check({tag, "_par"}, 32'(par_out), 32'(v));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [3:0] p);
    en = e; mode = m; par_in = p;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 3'd0; par_in = 4'h0;
    ser_in_l = 1'b0; ser_in_r = 1'b0; start = 1'b0; amt = '0;
    tick();
    check_st("reset", 4'b0000, 1'b0, 1'b0);
`ifdef UNIV_REG_PARITY_EN
    check("reset_parity", 32'(parity), 32'd0);
`endif

    reset = 1'b0;
    drive(1'b1, 3'd1, 4'b1001); tick();
    check("load", 32'(par_out), 32'b1001);
`ifdef UNIV_REG_PARITY_EN
    check("load_parity", 32'(parity), 32'd0);
`endif

    drive(1'b1, 3'd2, 4'b0000); ser_in_r = 1'b1; tick();
    check("shl", 32'(par_out), 32'b0011);
    check("ser_out_l", 32'(ser_out_l), 32'd0);
    check("ser_out_r", 32'(ser_out_r), 32'd1);
    ser_in_r = 1'b0;

    drive(1'b1, 3'd3, 4'b0000); ser_in_l = 1'b0; tick();
    check("shr", 32'(par_out), 32'b0001);

    drive(1'b1, 3'd1, 4'b1000); tick();
    drive(1'b1, 3'd6, 4'b0000); tick();
    check("asr", 32'(par_out), 32'b1100);
    check("asr_ser_out_l", 32'(ser_out_l), 32'd1);

    drive(1'b0, 3'd7, 4'b0000); tick();
    check("en0_hold", 32'(par_out), 32'b1100);

    drive(1'b1, 3'd0, 4'b1111); tick();
    check("hold_mode", 32'(par_out), 32'b1100);

    drive(1'b1, 3'd7, 4'b0000); tick();
    check("clear", 32'(par_out), 32'b0000);

    drive(1'b1, 3'd1, 4'b0011); tick();
    drive(1'b1, 3'd5, 4'b0000); tick();
    check("rotr", 32'(par_out), 32'b1001);
    drive(1'b1, 3'd4, 4'b0000); tick();
    check("rotl", 32'(par_out), 32'b0011);

    // Multi-step ROTL x3 from 1011, with junk driven on inputs while running
    drive(1'b1, 3'd1, 4'b1011); tick();
    drive(1'b1, 3'd4, 4'b0000); start = 1'b1; amt = 3'd3; tick();
    check_st("rotl3_c1", 4'b1011, 1'b1, 1'b0);
    drive(1'b1, 3'd7, 4'b1111); start = 1'b1; amt = 3'd1; tick();
    check_st("rotl3_c2", 4'b0111, 1'b1, 1'b0);
    tick();
    check_st("rotl3_c3", 4'b1110, 1'b1, 1'b0);
    tick();
    check_st("rotl3_done", 4'b1101, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 4'b0000); start = 1'b0; amt = '0; tick();
    check_st("rotl3_after", 4'b1101, 1'b0, 1'b0);

    // amt=0, then a start accepted in the done cycle
    drive(1'b1, 3'd1, 4'b0110); tick();
    drive(1'b1, 3'd2, 4'b0000); start = 1'b1; amt = 3'd0; tick();
    check_st("amt0", 4'b0110, 1'b0, 1'b1);
    drive(1'b0, 3'd4, 4'b0000); start = 1'b1; amt = 3'd1; tick();
    check_st("b2b_c1", 4'b0110, 1'b1, 1'b0);
    start = 1'b0; amt = '0; tick();
    check_st("b2b_done", 4'b1100, 1'b0, 1'b1);

    // start with LOAD is ignored: plain LOAD
    drive(1'b1, 3'd1, 4'b0101); start = 1'b1; amt = 3'd2; tick();
    check_st("start_load", 4'b0101, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 4'b0000); start = 1'b0; amt = '0; tick();
    check_st("start_load2", 4'b0101, 1'b0, 1'b0);

    // ROTR x4 from 1010 aborted by reset after two steps
    drive(1'b1, 3'd1, 4'b1010); tick();
    drive(1'b0, 3'd5, 4'b0000); start = 1'b1; amt = 3'd4; tick();
    start = 1'b0; amt = '0; tick();
    check("abort_step1", 32'(par_out), 32'b0101);
    tick();
    check("abort_step2", 32'(par_out), 32'b1010);
    reset = 1'b1; tick();
    check_st("abort_reset", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0; tick();
    check_st("abort_nodone", 4'b0000, 1'b0, 1'b0);

    // ROTL by WIDTH returns the original value
    drive(1'b1, 3'd1, 4'b1011); tick();
    drive(1'b0, 3'd4, 4'b0000); start = 1'b1; amt = 3'd4; tick();
    start = 1'b0; amt = '0;
    tick(); tick(); tick();
    check_st("rotl4_c4", 4'b1101, 1'b1, 1'b0);
    tick();
    check_st("rotl4_done", 4'b1011, 1'b0, 1'b1);

    // Multi-step SHR samples ser_in_l live
    drive(1'b1, 3'd7, 4'b0000); tick();
    drive(1'b0, 3'd3, 4'b0000); start = 1'b1; amt = 3'd2; tick();
    start = 1'b0; amt = '0; ser_in_l = 1'b1; tick();
    check("shr_live1", 32'(par_out), 32'b1000);
    ser_in_l = 1'b0; tick();
    check_st("shr_live2", 4'b0100, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
